// File: rtl/toggle_event_counter_if.sv
// Measurement request / result handshake bundle for toggle_event_counter.
interface toggle_event_counter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic [1:0]       edge_sel;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic             res_ovf;

    modport master (
        output start, win_len, edge_sel, res_ready,
        input  busy, res_valid, res_count, res_ovf
    );

    modport slave (
        input  start, win_len, edge_sel, res_ready,
        output busy, res_valid, res_count, res_ovf
    );
endinterface

// File: rtl/toggle_event_counter.sv
// Synchronises an asynchronous flop output, detects selected edges and counts them
// over a programmable window, returning the count through a valid/ready handshake.
//
//  state  | meaning
//  IDLE   | waiting for start
//  COUNT  | window running, edges accumulated
//  REPORT | result held until res_ready
module toggle_event_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int WIN_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    output logic                   edge_pulse,
    toggle_event_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d;
    logic                   rise, fall, pulse_nxt;
    logic [1:0]             sel;
    logic [WIN_W-1:0]       wcnt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   ovf, ovf_nxt;
    logic                   win_last;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_comb begin
        pulse_nxt = rise;
        if (sel[1])
            pulse_nxt = rise | fall;
        else if (sel[0])
            pulse_nxt = fall;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= '0;
            s_d        <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], din};
            s_d        <= s;
            edge_pulse <= pulse_nxt;
        end
    end

    assign win_last = (wcnt == WIN_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.win_len != '0) ? COUNT : REPORT;
            COUNT:   if (win_last) state_nxt = REPORT;
            REPORT:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating accumulate; an edge that finds the counter full marks overflow.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (edge_pulse) begin
            if (cnt == '1)
                ovf_nxt = 1'b1;
            else
                cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel           <= 2'b00;
            wcnt          <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.res_count <= '0;
            bus.res_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sel  <= bus.edge_sel;
                        wcnt <= bus.win_len;
                        cnt  <= '0;
                        ovf  <= 1'b0;
                        if (bus.win_len == '0) begin
                            bus.res_count <= '0;
                            bus.res_ovf   <= 1'b0;
                        end
                    end
                end
                COUNT: begin
                    wcnt <= wcnt - WIN_W'(1);
                    cnt  <= cnt_nxt;
                    ovf  <= ovf_nxt;
                    if (win_last) begin
                        bus.res_count <= cnt_nxt;
                        bus.res_ovf   <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = (state == REPORT);
endmodule

// File: tb/tb_toggle_event_counter.sv
// Directed bench for toggle_event_counter: 16-bit instance plus a 4-bit instance for saturation.
module tb_toggle_event_counter;
    logic clk = 1'b0;
    logic rst;
    logic din;
    logic pulse16, pulse4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic din_hist [0:8191];

    toggle_event_counter_if #(.CNT_W(16), .WIN_W(16)) bus16 ();
    toggle_event_counter_if #(.CNT_W(4),  .WIN_W(16)) bus4 ();

    toggle_event_counter #(.SYNC_STAGES(2), .CNT_W(16), .WIN_W(16)) dut16 (
        .clk(clk), .rst(rst), .din(din), .edge_pulse(pulse16), .bus(bus16)
    );

    toggle_event_counter #(.SYNC_STAGES(2), .CNT_W(4), .WIN_W(16)) dut4 (
        .clk(clk), .rst(rst), .din(din), .edge_pulse(pulse4), .bus(bus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        din_hist[cyc % 8192] = din;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic settle(input int n);
        din = 1'b0;
        for (int i = 0; i < n; i++) tick;
    endtask

    // Expected pulse in cycle c: din edge set in cycle c-3 (two sync flops + output register).
    function automatic logic exp_pulse(input int c, input logic [1:0] sel);
        logic a, b;
        if (c < 4) return 1'b0;
        a = din_hist[(c-3) % 8192];
        b = din_hist[(c-4) % 8192];
        if (sel[1]) return a ^ b;
        if (sel[0]) return ~a & b;
        return a & ~b;
    endfunction

    // 40-cycle window, three 4-cycle high pulses of din beginning 5 cycles after start.
    task automatic run16(input string t, input logic [1:0] sel, input int exp_cnt);
        int npulse;
        npulse = 0;
        bus16.start    = 1'b1;
        bus16.win_len  = 16'd40;
        bus16.edge_sel = sel;
        tick;
        bus16.start    = 1'b0;
        bus16.win_len  = 16'd7;
        bus16.edge_sel = 2'b01;
        for (int r = 1; r <= 41; r++) begin
            if (r <= 40) begin
                chk({t, "_pulse"}, pulse16, exp_pulse(cyc, sel));
                if (pulse16) npulse++;
            end
            if (r == 40) begin
                chk({t, "_busy_last"}, bus16.busy, 1);
                chk({t, "_valid_early"}, bus16.res_valid, 0);
            end
            if (r == 41) begin
                chk({t, "_valid"}, bus16.res_valid, 1);
                chk({t, "_count"}, bus16.res_count, exp_cnt);
                chk({t, "_ovf"}, bus16.res_ovf, 0);
                chk({t, "_npulse"}, npulse, exp_cnt);
            end
            din = (r >= 5 && r < 25) ? (((r - 5) % 8) < 4) : 1'b0;
            if (r < 41) tick;
        end
    endtask

    initial begin
        logic saw;
        rst = 1'b0;
        din = 1'b0;
        bus16.start = 1'b0; bus16.win_len = '0; bus16.edge_sel = 2'b00; bus16.res_ready = 1'b0;
        bus4.start  = 1'b0; bus4.win_len  = '0; bus4.edge_sel  = 2'b00; bus4.res_ready  = 1'b0;
        tick;
        tick;
        chk("rst_busy", bus16.busy, 0);
        chk("rst_valid", bus16.res_valid, 0);
        chk("rst_count", bus16.res_count, 0);
        chk("rst_pulse", pulse16, 0);
        rst = 1'b1;
        settle(4);

        // T2 rising edges only
        run16("t2", 2'b00, 3);
        bus16.res_ready = 1'b1;
        tick;
        bus16.res_ready = 1'b0;
        chk("t2_idle_valid", bus16.res_valid, 0);
        chk("t2_idle_busy", bus16.busy, 0);
        chk("t2_hold_count", bus16.res_count, 3);
        settle(6);

        // T1 reset mid-COUNT with din toggling every cycle
        bus16.start = 1'b1; bus16.win_len = 16'd100; bus16.edge_sel = 2'b10;
        tick;
        bus16.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            din = ~din;
            tick;
        end
        chk("t1_pulse_pre", pulse16, 1);
        chk("t1_busy_pre", bus16.busy, 1);
        rst = 1'b0;
        #1;
        chk("t1_busy", bus16.busy, 0);
        chk("t1_valid", bus16.res_valid, 0);
        chk("t1_count", bus16.res_count, 0);
        chk("t1_ovf", bus16.res_ovf, 0);
        chk("t1_pulse", pulse16, 0);
        tick;
        rst = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 60; i++) begin
            din = ~din;
            tick;
            saw = saw | bus16.res_valid | bus16.busy;
        end
        chk("t1_no_result", saw, 0);
        settle(6);

        // T3 both edges, latency checked per cycle
        run16("t3", 2'b10, 6);

        // T5 backpressure while pulsing start and toggling din
        for (int i = 0; i < 6; i++) begin
            bus16.start   = (i % 2 == 0);
            bus16.win_len = '0;
            din = ~din;
            tick;
            chk("t5_valid", bus16.res_valid, 1);
            chk("t5_count", bus16.res_count, 6);
            chk("t5_ovf", bus16.res_ovf, 0);
        end
        bus16.res_ready = 1'b1;
        bus16.start     = 1'b1;
        tick;
        bus16.res_ready = 1'b0;
        bus16.start     = 1'b0;
        chk("t5_idle_valid", bus16.res_valid, 0);
        chk("t5_idle_busy", bus16.busy, 0);
        tick;
        chk("t5_start_ignored", bus16.busy, 0);
        chk("t5_keep_count", bus16.res_count, 6);
        settle(6);

        // T6 zero-length window
        bus16.start = 1'b1; bus16.win_len = '0; bus16.edge_sel = 2'b00;
        tick;
        bus16.start = 1'b0;
        chk("t6_valid", bus16.res_valid, 1);
        chk("t6_count", bus16.res_count, 0);
        chk("t6_ovf", bus16.res_ovf, 0);
        bus16.res_ready = 1'b1;
        tick;
        bus16.res_ready = 1'b0;
        chk("t6_idle", bus16.busy, 0);
        settle(6);

        // T4 saturation on the 4-bit instance: 20 rising edges in a 200-cycle window
        bus4.start = 1'b1; bus4.win_len = 16'd200; bus4.edge_sel = 2'b00;
        tick;
        bus4.start = 1'b0;
        for (int r = 1; r <= 201; r++) begin
            if (r == 200) chk("t4_valid_early", bus4.res_valid, 0);
            if (r == 201) begin
                chk("t4_valid", bus4.res_valid, 1);
                chk("t4_count", bus4.res_count, 15);
                chk("t4_ovf", bus4.res_ovf, 1);
            end
            din = (r >= 5 && r < 85) ? (((r - 5) % 4) < 2) : 1'b0;
            if (r < 201) tick;
        end
        bus4.res_ready = 1'b1;
        tick;
        bus4.res_ready = 1'b0;
        chk("t4_idle", bus4.busy, 0);
        chk("t4_keep_ovf", bus4.res_ovf, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
